// File: rtl/mem_controller_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        FETCH = 3'd3,
        DONE  = 3'd4
    } mc_state_e;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [2:0] WIDTH_B = 3'd1;
    localparam logic [2:0] WIDTH_H = 3'd2;
    localparam logic [2:0] WIDTH_W = 3'd4;

    localparam logic [1:0] MC_IO_ADDR_HI = 2'b11;

    // Execute-stage ROB tag width and the "no dependency" tag sentinel.
    localparam int ROB_WIDTH = 4;
    localparam logic [ROB_WIDTH:0] NON_DEP = {1'b1, {ROB_WIDTH{1'b0}}};

    typedef struct packed {
        logic [2:0]  width;
        logic [31:0] data;
    } req_t;

    function automatic logic [2:0] norm_width(input logic [2:0] w);
        case (w)
            WIDTH_B: return WIDTH_B;
            WIDTH_H: return WIDTH_H;
            default: return WIDTH_W;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [2:0] w);
        case (w)
            WIDTH_B: return 2'd0;
            WIDTH_H: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mc_arbiter.sv
// Grants one of LSB / fetch requesters, only while the controller is IDLE.
// Latency: combinational. Backpressure: requests outside IDLE (incl. DONE) get no grant.
// Tie-break: LSB wins, or fetch wins when MC_FETCH_PRIORITY_EN is defined.
module mc_arbiter
    import mem_controller_pkg::*;
(
    input  mc_state_e state,
    input  logic      lsb_req,
    input  logic      if_req,
    output logic      gnt_lsb,
    output logic      gnt_if
);

    always_comb begin
        gnt_lsb = 1'b0;
        gnt_if  = 1'b0;
        if (state == IDLE) begin
`ifdef MC_FETCH_PRIORITY_EN
            if (if_req)
                gnt_if = 1'b1;
            else if (lsb_req)
                gnt_lsb = 1'b1;
`else
            if (lsb_req)
                gnt_lsb = 1'b1;
            else if (if_req)
                gnt_if = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mem_controller.sv
// Byte-serial RAM/IO controller for LSB loads/stores and instruction fetch (MC_FETCH_PRIORITY_EN: fetch wins ties).
// Latency: load byte k at accept+3+k, fetch word at accept+6, store done at accept+width+1.
// Backpressure: one request at a time; IO writes stall while io_buffer_full; Sys_rdy low freezes all.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_ADDR_HI = MC_IO_ADDR_HI
) (
    input  logic                  Sys_clk,
    input  logic                  Sys_rst,
    input  logic                  Sys_rdy,
    input  logic                  RoBMC_pre_judge,
    input  logic                  LSBMC_en,
    input  logic                  LSBMC_wr,
    input  logic [2:0]            LSBMC_data_width,
    input  logic [31:0]           LSBMC_data,
    input  logic [ADDR_WIDTH-1:0] LSBMC_addr,
    output logic                  MCLSB_en,
    output logic [7:0]            MCLSB_data,
    output logic [1:0]            MCLSB_data_number,
    input  logic                  IFMC_en,
    input  logic [ADDR_WIDTH-1:0] IFMC_addr,
    output logic                  MCIF_en,
    output logic [31:0]           MCIF_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    mc_state_e             state;
    req_t                  req_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            cnt;
    logic                  a_vld, d_vld;
    logic [1:0]            a_idx, d_idx;
    logic [23:0]           word_q;

    logic                  flush;
    logic                  gnt_lsb, gnt_if;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [2:0]            acc_width;
    logic                  acc_wr, acc_stall, st_stall;

    assign flush     = ~RoBMC_pre_judge;
    assign acc_addr  = gnt_lsb ? LSBMC_addr : IFMC_addr;
    assign acc_width = gnt_lsb ? norm_width(LSBMC_data_width) : WIDTH_W;
    assign acc_wr    = gnt_lsb && (LSBMC_wr == WRITE);
    assign acc_stall = acc_wr && (acc_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign st_stall  = (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;

    // A flush cycle must not start a new speculative access.
    mc_arbiter u_arb (
        .state   (state),
        .lsb_req (LSBMC_en && RoBMC_pre_judge),
        .if_req  (IFMC_en && RoBMC_pre_judge),
        .gnt_lsb (gnt_lsb),
        .gnt_if  (gnt_if)
    );

    always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
            state             <= IDLE;
            req_q             <= '0;
            addr_q            <= '0;
            cnt               <= '0;
            a_vld             <= 1'b0;
            d_vld             <= 1'b0;
            a_idx             <= '0;
            d_idx             <= '0;
            word_q            <= '0;
            MCLSB_en          <= 1'b0;
            MCLSB_data        <= '0;
            MCLSB_data_number <= '0;
            MCIF_en           <= 1'b0;
            MCIF_data         <= '0;
            mem_dout          <= '0;
            mem_a             <= '0;
            mem_wr            <= 1'b0;
        end else if (Sys_rdy) begin
            MCLSB_en <= 1'b0;
            MCIF_en  <= 1'b0;
            mem_wr   <= 1'b0;
            // Read pipeline: a_* tracks the address on the bus, d_* the byte on mem_din.
            d_vld    <= a_vld;
            d_idx    <= a_idx;
            case (state)
                IDLE: begin
                    a_vld <= 1'b0;
                    if (gnt_lsb || gnt_if) begin
                        addr_q      <= acc_addr;
                        req_q.width <= acc_width;
                        req_q.data  <= LSBMC_data;
                        mem_a       <= acc_addr;
                        if (acc_wr) begin
                            state    <= STORE;
                            mem_dout <= LSBMC_data[7:0];
                            mem_wr   <= ~acc_stall;
                            cnt      <= acc_stall ? 3'd0 : 3'd1;
                        end else begin
                            state <= gnt_lsb ? LOAD : FETCH;
                            a_vld <= 1'b1;
                            a_idx <= 2'd0;
                            cnt   <= 3'd1;
                        end
                    end
                end
                LOAD, FETCH: begin
                    if (flush) begin
                        state <= IDLE;
                        a_vld <= 1'b0;
                        d_vld <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        if (cnt < req_q.width) begin
                            mem_a <= addr_q + ADDR_WIDTH'(cnt);
                            a_vld <= 1'b1;
                            a_idx <= cnt[1:0];
                            cnt   <= cnt + 3'd1;
                        end else begin
                            a_vld <= 1'b0;
                        end
                        if (d_vld) begin
                            if (state == LOAD) begin
                                MCLSB_en          <= 1'b1;
                                MCLSB_data        <= mem_din;
                                MCLSB_data_number <= d_idx;
                            end else begin
                                case (d_idx)
                                    2'd0:    word_q[7:0]   <= mem_din;
                                    2'd1:    word_q[15:8]  <= mem_din;
                                    2'd2:    word_q[23:16] <= mem_din;
                                    default: begin
                                        MCIF_en   <= 1'b1;
                                        MCIF_data <= {mem_din, word_q};
                                    end
                                endcase
                            end
                            if (d_idx == last_idx(req_q.width)) begin
                                state <= DONE;
                                cnt   <= '0;
                            end
                        end
                    end
                end
                STORE: begin
                    // Committed stores ignore flush; only an IO-full stall can hold a byte.
                    if (cnt == req_q.width) begin
                        MCLSB_en          <= 1'b1;
                        MCLSB_data_number <= last_idx(req_q.width);
                        state             <= DONE;
                        cnt               <= '0;
                    end else if (!st_stall) begin
                        mem_a    <= addr_q + ADDR_WIDTH'(cnt);
                        mem_dout <= req_q.data[{cnt[1:0], 3'b000} +: 8];
                        mem_wr   <= 1'b1;
                        cnt      <= cnt + 3'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed, table-driven bench for mem_controller with a 4 KiB byte RAM model.
module tb_mem_controller;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst = 1'b1;
    logic        Sys_rdy = 1'b1;
    logic        RoBMC_pre_judge = 1'b1;
    logic        LSBMC_en = 1'b0;
    logic        LSBMC_wr = 1'b0;
    logic [2:0]  LSBMC_data_width = 3'd0;
    logic [31:0] LSBMC_data = 32'h0;
    logic [31:0] LSBMC_addr = 32'h0;
    logic        MCLSB_en;
    logic [7:0]  MCLSB_data;
    logic [1:0]  MCLSB_data_number;
    logic        IFMC_en = 1'b0;
    logic [31:0] IFMC_addr = 32'h0;
    logic        MCIF_en;
    logic [31:0] MCIF_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    mem_controller dut (
        .Sys_clk           (Sys_clk),
        .Sys_rst           (Sys_rst),
        .Sys_rdy           (Sys_rdy),
        .RoBMC_pre_judge   (RoBMC_pre_judge),
        .LSBMC_en          (LSBMC_en),
        .LSBMC_wr          (LSBMC_wr),
        .LSBMC_data_width  (LSBMC_data_width),
        .LSBMC_data        (LSBMC_data),
        .LSBMC_addr        (LSBMC_addr),
        .MCLSB_en          (MCLSB_en),
        .MCLSB_data        (MCLSB_data),
        .MCLSB_data_number (MCLSB_data_number),
        .IFMC_en           (IFMC_en),
        .IFMC_addr         (IFMC_addr),
        .MCIF_en           (MCIF_en),
        .MCIF_data         (MCIF_data),
        .mem_din           (mem_din),
        .mem_dout          (mem_dout),
        .mem_a             (mem_a),
        .mem_wr            (mem_wr),
        .io_buffer_full    (io_buffer_full)
    );

    always #5 Sys_clk = ~Sys_clk;

    // RAM: read data one cycle after the address; preset contents while in reset.
    logic [7:0] ram [0:4095];
    always @(posedge Sys_clk) begin
        if (Sys_rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11; ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33; ram[12'h103] <= 8'h44;
            ram[12'h104] <= 8'h55; ram[12'h105] <= 8'h66;
            ram[12'h106] <= 8'h77; ram[12'h107] <= 8'h88;
            ram[12'hFFE] <= 8'hA1; ram[12'hFFF] <= 8'hA2;
            ram[12'h000] <= 8'hA3; ram[12'h001] <= 8'hA4;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    // Event logs; rel = cycle index relative to the accept edge E0.
    localparam int LOGN = 256;
    int cyc = 0;
    int e0  = 0;
    int ls_n = 0, if_n = 0, wr_n = 0;
    int          ls_rel [LOGN];
    logic [7:0]  ls_dat [LOGN];
    logic [1:0]  ls_num [LOGN];
    int          if_rel [LOGN];
    logic [31:0] if_dat [LOGN];
    int          wr_rel [LOGN];
    logic [31:0] wr_adr [LOGN];
    logic [7:0]  wr_dat [LOGN];

    always @(posedge Sys_clk) cyc <= cyc + 1;

    always @(negedge Sys_clk) begin
        if (MCLSB_en && ls_n < LOGN) begin
            ls_rel[ls_n] <= cyc - e0 + 1;
            ls_dat[ls_n] <= MCLSB_data;
            ls_num[ls_n] <= MCLSB_data_number;
            ls_n         <= ls_n + 1;
        end
        if (MCIF_en && if_n < LOGN) begin
            if_rel[if_n] <= cyc - e0 + 1;
            if_dat[if_n] <= MCIF_data;
            if_n         <= if_n + 1;
        end
        if (mem_wr && wr_n < LOGN) begin
            wr_rel[wr_n] <= cyc - e0 + 1;
            wr_adr[wr_n] <= mem_a;
            wr_dat[wr_n] <= mem_dout;
            wr_n         <= wr_n + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int bls, bif, bwr;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        @(negedge Sys_clk);
    endtask

    task automatic waitn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called at a negedge; the request is sampled at the following posedge (E0).
    task automatic req_lsb(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        bls = ls_n; bif = if_n; bwr = wr_n;
        e0 = cyc + 1;
        LSBMC_en = 1'b1; LSBMC_wr = wr; LSBMC_data_width = w;
        LSBMC_addr = a; LSBMC_data = d;
    endtask

    task automatic req_if(input logic [31:0] a);
        bls = ls_n; bif = if_n; bwr = wr_n;
        e0 = cyc + 1;
        IFMC_en = 1'b1; IFMC_addr = a;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
    endfunction

    function automatic logic [31:0] ls_word(input int from, input int to);
        logic [31:0] w;
        w = 32'h0;
        for (int j = from; j < to; j++) w = w | (32'(ls_dat[j]) << (8 * int'(ls_num[j])));
        return w;
    endfunction

    typedef struct {
        bit          src_if;
        bit          wr;
        logic [2:0]  width;
        logic [31:0] addr;
        logic [31:0] data;
        int          exp_n;
        int          exp_rel;
        logic [1:0]  exp_num;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 11;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b0, 1'b0, 3'd4, 32'h0000_0100, 32'h0,         4, 6, 2'd3, 32'h4433_2211};
        vt[1]  = '{1'b0, 1'b0, 3'd1, 32'h0000_0102, 32'h0,         1, 3, 2'd0, 32'h0000_0033};
        vt[2]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0101, 32'h0,         2, 4, 2'd1, 32'h0000_3322};
        vt[3]  = '{1'b0, 1'b0, 3'd3, 32'h0000_0100, 32'h0,         4, 6, 2'd3, 32'h4433_2211};
        vt[4]  = '{1'b0, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0,         4, 6, 2'd3, 32'hA4A3_A2A1};
        vt[5]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0200, 32'h0000_BEEF, 2, 3, 2'd1, 32'h0000_BEEF};
        vt[6]  = '{1'b0, 1'b1, 3'd4, 32'h0000_0210, 32'hDEAD_BEEF, 4, 5, 2'd3, 32'hDEAD_BEEF};
        vt[7]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0220, 32'h1234_5678, 1, 2, 2'd0, 32'h0000_0078};
        vt[8]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0230, 32'h0102_0304, 4, 5, 2'd3, 32'h0102_0304};
        vt[9]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0104, 32'h0,         1, 6, 2'd0, 32'h8877_6655};
        vt[10] = '{1'b0, 1'b0, 3'd2, 32'h0000_0200, 32'h0,         2, 4, 2'd1, 32'h0000_BEEF};

        // Reset state
        repeat (3) @(negedge Sys_clk);
        chk("rst_pulses", {29'h0, MCLSB_en, MCIF_en, mem_wr}, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_bytes", {14'h0, MCLSB_data, MCLSB_data_number, mem_dout}, 32'h0);
        chk("rst_ifdata", MCIF_data, 32'h0);
        Sys_rst = 1'b0;
        waitn(2);

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            if (vt[i].src_if) req_if(vt[i].addr);
            else req_lsb(vt[i].wr, vt[i].width, vt[i].addr, vt[i].data);
            tick();
            LSBMC_en = 1'b0;
            IFMC_en  = 1'b0;
            waitn(14);
            if (vt[i].src_if) begin
                chk($sformatf("v%0d_cnt", i), if_n - bif, vt[i].exp_n);
                chk($sformatf("v%0d_rel", i), (if_n > bif) ? if_rel[if_n-1] : -1, vt[i].exp_rel);
                chk($sformatf("v%0d_lsb_quiet", i), ls_n - bls, 0);
                chk($sformatf("v%0d_word", i), (if_n > bif) ? if_dat[if_n-1] : 32'hFFFF_FFFF, vt[i].exp_word);
            end else begin
                chk($sformatf("v%0d_cnt", i), vt[i].wr ? (wr_n - bwr) : (ls_n - bls), vt[i].exp_n);
                chk($sformatf("v%0d_rel", i), (ls_n > bls) ? ls_rel[ls_n-1] : -1, vt[i].exp_rel);
                chk($sformatf("v%0d_num", i), (ls_n > bls) ? {30'h0, ls_num[ls_n-1]} : 32'hFFFF_FFFF,
                    {30'h0, vt[i].exp_num});
                chk($sformatf("v%0d_word", i), vt[i].wr ? ram_word(vt[i].addr) : ls_word(bls, ls_n),
                    vt[i].exp_word);
            end
        end

        // Request in a flush cycle is not accepted
        req_lsb(1'b0, 3'd1, 32'h100, 32'h0);
        RoBMC_pre_judge = 1'b0;
        tick();
        LSBMC_en = 1'b0;
        RoBMC_pre_judge = 1'b1;
        waitn(10);
        chk("idle_flush_pulses", ls_n - bls, 0);

        // Simultaneous lb and fetch; each requester holds en until served
        req_lsb(1'b0, 3'd1, 32'h100, 32'h0);
        req_if(32'h104);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (MCLSB_en) LSBMC_en = 1'b0;
            if (MCIF_en) IFMC_en = 1'b0;
        end
        LSBMC_en = 1'b0;
        IFMC_en  = 1'b0;
        waitn(3);
`ifdef MC_FETCH_PRIORITY_EN
        chk("tie_lsb_rel", (ls_n > bls) ? ls_rel[bls] : -1, 10);
        chk("tie_if_rel", (if_n > bif) ? if_rel[bif] : -1, 6);
`else
        chk("tie_lsb_rel", (ls_n > bls) ? ls_rel[bls] : -1, 3);
        chk("tie_if_rel", (if_n > bif) ? if_rel[bif] : -1, 10);
`endif
        chk("tie_lsb_data", (ls_n > bls) ? {24'h0, ls_dat[bls]} : 32'hFFFF_FFFF, 32'h11);
        chk("tie_if_data", (if_n > bif) ? if_dat[bif] : 32'hFFFF_FFFF, 32'h8877_6655);

        // Flush in cycle E0+3 of a fetch, then an lb sampled at E0+4
        req_if(32'h100);
        tick();
        IFMC_en = 1'b0;
        tick();
        tick();
        RoBMC_pre_judge = 1'b0;
        tick();
        RoBMC_pre_judge = 1'b1;
        begin
            int if_base;
            if_base = bif;
            req_lsb(1'b0, 3'd1, 32'h100, 32'h0);
            tick();
            LSBMC_en = 1'b0;
            waitn(12);
            chk("flush_fetch_no_mcif", if_n - if_base, 0);
        end
        chk("flush_then_lb_rel", (ls_n > bls) ? ls_rel[ls_n-1] : -1, 3);
        chk("flush_then_lb_data", (ls_n > bls) ? {24'h0, ls_dat[ls_n-1]} : 32'hFFFF_FFFF, 32'h11);

        // Same flush timing during a word store
        req_lsb(1'b1, 3'd4, 32'h240, 32'hCAFE_F00D);
        tick();
        LSBMC_en = 1'b0;
        tick();
        tick();
        RoBMC_pre_judge = 1'b0;
        tick();
        RoBMC_pre_judge = 1'b1;
        waitn(10);
        chk("flush_sw_writes", wr_n - bwr, 4);
        chk("flush_sw_done_rel", (ls_n > bls) ? ls_rel[ls_n-1] : -1, 5);
        chk("flush_sw_word", ram_word(32'h240), 32'hCAFE_F00D);

        // sb to the IO region with the IO sink full for three edges
        req_lsb(1'b1, 3'd1, 32'h0003_0000, 32'h0000_00A5);
        io_buffer_full = 1'b1;
        tick();
        LSBMC_en = 1'b0;
        tick();
        tick();
        io_buffer_full = 1'b0;
        waitn(10);
        chk("io_writes", wr_n - bwr, 1);
        chk("io_wr_rel", (wr_n > bwr) ? wr_rel[bwr] : -1, 4);
        chk("io_wr_addr", (wr_n > bwr) ? wr_adr[bwr] : 32'hFFFF_FFFF, 32'h0003_0000);
        chk("io_wr_data", (wr_n > bwr) ? {24'h0, wr_dat[bwr]} : 32'hFFFF_FFFF, 32'hA5);
        chk("io_done_rel", (ls_n > bls) ? ls_rel[ls_n-1] : -1, 5);

        // Reset pulsed in the middle of a word load
        req_lsb(1'b0, 3'd4, 32'h100, 32'h0);
        tick();
        LSBMC_en = 1'b0;
        tick();
        chk("midlw_mem_a", mem_a, 32'h0000_0101);
        Sys_rst = 1'b1;
        #1;
        chk("midlw_rst_mem_a", mem_a, 32'h0);
        chk("midlw_rst_lsbdata", {24'h0, MCLSB_data}, 32'h0);
        chk("midlw_rst_pulses", {29'h0, MCLSB_en, MCIF_en, mem_wr}, 32'h0);
        @(negedge Sys_clk);
        Sys_rst = 1'b0;
        waitn(10);
        chk("midlw_no_pulses", ls_n - bls, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
